// File: rtl/random_num_generator_pkg.sv
// rng_pkg: LFSR width, taps and reset seed shared by RTL and bench.
// lfsr_next gives the one-step Fibonacci successor of a state.
package rng_pkg;

  localparam int RNG_WIDTH = 4;
  localparam logic [RNG_WIDTH-1:0] RNG_TAPS = 4'b1100;
  localparam logic [RNG_WIDTH-1:0] RNG_RESET_SEED = 4'b0001;

  function automatic logic [RNG_WIDTH-1:0] lfsr_next(
    input logic [RNG_WIDTH-1:0] state,
    input logic [RNG_WIDTH-1:0] taps
  );
    return {state[RNG_WIDTH-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/random_num_generator_if.sv
// Seed-load strobe, seed value and random bit of the generator.
// The master drives load/seed; the slave returns out.
interface random_num_generator_if #(
  parameter int WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] seed;
  logic             out;

  modport master (
    output load,
    output seed,
    input  out
  );

  modport slave (
    input  load,
    input  seed,
    output out
  );

endinterface

// File: rtl/random_num_generator_lfsr_next_state.sv
// Combinational Fibonacci LFSR step: shift left,
// feed the parity of the tapped bits into the LSB.
module lfsr_next_state #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] next
);

  // shift with XOR feedback
  always_comb begin
    next = {state[WIDTH-2:0], ^(state & taps)};
  end

endmodule

// File: rtl/random_num_generator.sv
// Free-running LFSR random bit source with synchronous seed load.
// Define RNG_ZERO_GUARD_EN to replace any all-zero state with the reset seed.
module random_num_generator
  import rng_pkg::*;
#(
  parameter int               WIDTH      = RNG_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = RNG_TAPS,
  parameter logic [WIDTH-1:0] RESET_SEED = RNG_RESET_SEED
) (
  input logic                    clk,
  input logic                    rst,
  random_num_generator_if.slave  bus
);

  logic [WIDTH-1:0] state = RESET_SEED;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] nxt;

  lfsr_next_state #(
    .WIDTH (WIDTH)
  ) u_next (
    .state (state),
    .taps  (TAPS),
    .next  (shifted)
  );

  // load beats shift; optionally never let zero in
  always_comb begin
    nxt = shifted;
    if (bus.load) begin
      nxt = bus.seed;
    end
`ifdef RNG_ZERO_GUARD_EN
    if (nxt == '0) begin
      nxt = RESET_SEED;
    end
`endif
  end

  // state register, async reset to the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_SEED;
    end else begin
      state <= nxt;
    end
  end

  assign bus.out = state[WIDTH-1];

endmodule

// File: tb/tb_random_num_generator.sv
// Scoreboard bench for random_num_generator.
// Expected states are queued as stimulus is driven and popped per edge.
module tb_random_num_generator;
  import rng_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  logic [3:0] exp_q[$];

  logic [3:0] seq_tab [0:14] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
    4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
    4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000
  };
  logic out_tab [0:14] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1
  };

  random_num_generator_if #(.WIDTH(4)) bus ();

  random_num_generator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick_check(input string name);
    logic [3:0] e;
    @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, state=%b", name, dut.state);
    end else begin
      e = exp_q.pop_front();
      if (dut.state !== e) begin
        errors++;
        $display("FAIL %s: state=%b expected=%b", name, dut.state, e);
      end
      vectors++;
      if (bus.out !== e[3]) begin
        errors++;
        $display("FAIL %s: out=%b expected=%b", name, bus.out, e[3]);
      end
    end
  endtask

  task automatic check_now(input string name, input logic [3:0] e);
    vectors++;
    if (dut.state !== e) begin
      errors++;
      $display("FAIL %s: state=%b expected=%b", name, dut.state, e);
    end
    vectors++;
    if (bus.out !== e[3]) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b", name, bus.out, e[3]);
    end
  endtask

  task automatic test_reset();
    bus.load = 1'b0;
    bus.seed = 4'b0000;
    rst = 1'b1;
    #12;
    check_now("reset_hold", 4'b0001);
    @(posedge clk);
    #1;
    check_now("reset_edge", 4'b0001);
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check_now("seq_start", 4'b0001);
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(seq_tab[i % 15]);
      tick_check("seq");
      vectors++;
      if (bus.out !== out_tab[i % 15]) begin
        errors++;
        $display("FAIL seq_out[%0d]: out=%b expected=%b",
                 i, bus.out, out_tab[i % 15]);
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_now("async_rst", 4'b0001);
    rst = 1'b0;
    exp_q.push_back(4'b0010);
    tick_check("after_async_rst");
  endtask

  task automatic test_load();
    bus.seed = 4'b1010;
    bus.load = 1'b1;
    exp_q.push_back(4'b1010);
    tick_check("load");
    bus.load = 1'b0;
    bus.seed = 4'b0000;
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1011);
    exp_q.push_back(4'b0111);
    repeat (3) tick_check("after_load");
  endtask

  task automatic test_load_held();
    bus.seed = 4'b0110;
    bus.load = 1'b1;
    repeat (3) begin
      exp_q.push_back(4'b0110);
      tick_check("load_held");
    end
    bus.load = 1'b0;
    exp_q.push_back(4'b1101);
    tick_check("load_release");
  endtask

  task automatic test_zero_seed();
    bus.seed = 4'b0000;
    bus.load = 1'b1;
`ifdef RNG_ZERO_GUARD_EN
    exp_q.push_back(4'b0001);
    tick_check("zero_load_guard");
    bus.load = 1'b0;
    exp_q.push_back(4'b0010);
    tick_check("zero_guard_next");
`else
    exp_q.push_back(4'b0000);
    tick_check("zero_load");
    bus.load = 1'b0;
    repeat (4) begin
      exp_q.push_back(4'b0000);
      tick_check("zero_lock");
    end
`endif
    bus.seed = 4'b1001;
    bus.load = 1'b1;
    exp_q.push_back(4'b1001);
    tick_check("zero_recover");
    bus.load = 1'b0;
    exp_q.push_back(4'b0011);
    tick_check("zero_recover_next");
  endtask

  task automatic test_free_run();
    logic [3:0] hist [0:1499];
    logic [3:0] model;
    int ones;
    bit dup;
    ones = 0;
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model = RNG_RESET_SEED;
    for (int i = 0; i < 1500; i++) begin
      model = lfsr_next(model, RNG_TAPS);
      exp_q.push_back(model);
      tick_check("free_run");
      hist[i] = dut.state;
      if (bus.out === 1'b1) ones++;
      dup = 1'b0;
      for (int j = (i > 14 ? i - 14 : 0); j < i; j++) begin
        if (hist[j] === hist[i]) dup = 1'b1;
      end
      vectors++;
      if (dup) begin
        errors++;
        $display("FAIL window[%0d]: state %b repeats within 15", i, hist[i]);
      end
    end
    vectors++;
    if (ones !== 800) begin
      errors++;
      $display("FAIL ones_count: got=%0d expected=800", ones);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_async_reset();
    test_load();
    test_load_held();
    test_zero_seed();
    test_free_run();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
